mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory stage of a small in-order pipeline.
//
// Non-memory instructions from EX are passed to writeback one cycle later.
// Aligned loads and stores run a single-beat bus transaction. The stage stalls
// EX while that transaction is outstanding. Misaligned accesses, and requests
// with both read and write set, are not sent to the bus. They retire as a
// faulting writeback with the register write suppressed.
//
// Configuration macro: MEM_TIMEOUT_EN
//   When defined, a bus transaction with no dm_ack for TIMEOUT_CYCLES BUS
//   cycles is aborted and retires with mem_fault. When undefined, the stage
//   waits for dm_ack indefinitely.
//
// Ports
//   clk_i, rst_i          clock; asynchronous active-high reset
//   ex_valid_i            EX presents a completed instruction
//   ex_mem_read_i         load request
//   ex_mem_write_i        store request
//   ex_addr_i             data memory byte address
//   ex_wdata_i            store data
//   ex_result_i           ALU result for non-memory instructions
//   ex_dest_reg_i         destination register index
//   ex_w_enable_i         register write request
//   stall_o               high while a bus transaction is outstanding
//   dm_req_o, dm_we_o     bus request and write strobe
//   dm_addr_o, dm_wdata_o bus address and write data
//   dm_rdata_i, dm_ack_i  bus read data and one-cycle completion pulse
//   wb_valid_o            one-cycle writeback strobe
//   wb_data_o             writeback value
//   wb_dest_reg_o         writeback register index
//   wb_w_enable_o         register file write enable (qualified by wb_valid_o)
//   mem_fault_o           one-cycle fault strobe, coincident with wb_valid_o

module mem_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ex_valid_i,
  input  logic        ex_mem_read_i,
  input  logic        ex_mem_write_i,
  input  logic [31:0] ex_addr_i,
  input  logic [31:0] ex_wdata_i,
  input  logic [31:0] ex_result_i,
  input  logic [2:0]  ex_dest_reg_i,
  input  logic        ex_w_enable_i,
  output logic        stall_o,
  output logic        dm_req_o,
  output logic        dm_we_o,
  output logic [31:0] dm_addr_o,
  output logic [31:0] dm_wdata_o,
  input  logic [31:0] dm_rdata_i,
  input  logic        dm_ack_i,
  output logic        wb_valid_o,
  output logic [31:0] wb_data_o,
  output logic [2:0]  wb_dest_reg_o,
  output logic        wb_w_enable_o,
  output logic        mem_fault_o
);

  typedef enum logic {
    IDLE = 1'b0,
    BUS  = 1'b1
  } stateT;

  // Reject a zero-length timeout at elaboration time.
  if (TIMEOUT_CYCLES < 1) begin : gBadTimeout
    $error("mem_stage: TIMEOUT_CYCLES must be at least 1");
  end

  stateT       state_q, state_d;
  logic        dmReq_q, dmReq_d;
  logic        dmWe_q, dmWe_d;
  logic [31:0] dmAddr_q, dmAddr_d;
  logic [31:0] dmWdata_q, dmWdata_d;
  logic [2:0]  memDest_q, memDest_d;
  logic        wbValid_q, wbValid_d;
  logic [31:0] wbData_q, wbData_d;
  logic [2:0]  wbDest_q, wbDest_d;
  logic        wbWen_q, wbWen_d;
  logic        fault_q, fault_d;
  logic        busAbort;

`ifdef MEM_TIMEOUT_EN
  localparam int CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] busCnt_q, busCnt_d;
`endif

  // Request decode for the instruction EX is presenting.
  logic isMemOp, isLegalMem;
  assign isMemOp    = ex_mem_read_i | ex_mem_write_i;
  assign isLegalMem = (ex_mem_read_i ^ ex_mem_write_i) && (ex_addr_i[1:0] == 2'b00);

  // busCnt_q holds the number of BUS cycles already elapsed. The abort
  // therefore fires in the TIMEOUT_CYCLES-th BUS cycle, so dm_req is high for
  // exactly TIMEOUT_CYCLES cycles. An ack in that same cycle still wins.
`ifdef MEM_TIMEOUT_EN
  assign busAbort = (busCnt_q == CntW'(TIMEOUT_CYCLES - 1));
`else
  assign busAbort = 1'b0;
`endif

  // Next-state and output-register logic.
  always_comb begin
    state_d   = state_q;
    dmReq_d   = dmReq_q;
    dmWe_d    = dmWe_q;
    dmAddr_d  = dmAddr_q;
    dmWdata_d = dmWdata_q;
    memDest_d = memDest_q;
    wbValid_d = 1'b0;
    wbData_d  = wbData_q;
    wbDest_d  = wbDest_q;
    wbWen_d   = wbWen_q;
    fault_d   = 1'b0;
`ifdef MEM_TIMEOUT_EN
    busCnt_d  = busCnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (ex_valid_i) begin
          if (!isMemOp) begin
            wbValid_d = 1'b1;
            wbData_d  = ex_result_i;
            wbDest_d  = ex_dest_reg_i;
            wbWen_d   = ex_w_enable_i;
          end else if (isLegalMem) begin
            dmReq_d   = 1'b1;
            dmWe_d    = ex_mem_write_i;
            dmAddr_d  = ex_addr_i;
            dmWdata_d = ex_wdata_i;
            memDest_d = ex_dest_reg_i;
            state_d   = BUS;
`ifdef MEM_TIMEOUT_EN
            busCnt_d  = '0;
`endif
          end else begin
            wbValid_d = 1'b1;
            wbData_d  = 32'd0;
            wbDest_d  = ex_dest_reg_i;
            wbWen_d   = 1'b0;
            fault_d   = 1'b1;
          end
        end
      end

      BUS: begin
`ifdef MEM_TIMEOUT_EN
        busCnt_d = busCnt_q + 1'b1;
`endif
        if (dm_ack_i) begin
          dmReq_d   = 1'b0;
          dmWe_d    = 1'b0;
          wbValid_d = 1'b1;
          wbData_d  = dmWe_q ? 32'd0 : dm_rdata_i;
          wbDest_d  = memDest_q;
          wbWen_d   = ~dmWe_q;
          state_d   = IDLE;
`ifdef MEM_TIMEOUT_EN
          busCnt_d  = '0;
`endif
        end else if (busAbort) begin
          dmReq_d   = 1'b0;
          dmWe_d    = 1'b0;
          wbValid_d = 1'b1;
          wbData_d  = 32'd0;
          wbDest_d  = memDest_q;
          wbWen_d   = 1'b0;
          fault_d   = 1'b1;
          state_d   = IDLE;
`ifdef MEM_TIMEOUT_EN
          busCnt_d  = '0;
`endif
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers. Reset also abandons any bus transaction.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      dmReq_q   <= 1'b0;
      dmWe_q    <= 1'b0;
      dmAddr_q  <= 32'd0;
      dmWdata_q <= 32'd0;
      memDest_q <= 3'd0;
      wbValid_q <= 1'b0;
      wbData_q  <= 32'd0;
      wbDest_q  <= 3'd0;
      wbWen_q   <= 1'b0;
      fault_q   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      busCnt_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      dmReq_q   <= dmReq_d;
      dmWe_q    <= dmWe_d;
      dmAddr_q  <= dmAddr_d;
      dmWdata_q <= dmWdata_d;
      memDest_q <= memDest_d;
      wbValid_q <= wbValid_d;
      wbData_q  <= wbData_d;
      wbDest_q  <= wbDest_d;
      wbWen_q   <= wbWen_d;
      fault_q   <= fault_d;
`ifdef MEM_TIMEOUT_EN
      busCnt_q  <= busCnt_d;
`endif
    end
  end

  assign stall_o       = (state_q == BUS);
  assign dm_req_o      = dmReq_q;
  assign dm_we_o       = dmWe_q;
  assign dm_addr_o     = dmAddr_q;
  assign dm_wdata_o    = dmWdata_q;
  assign wb_valid_o    = wbValid_q;
  assign wb_data_o     = wbData_q;
  assign wb_dest_reg_o = wbDest_q;
  assign wb_w_enable_o = wbWen_q;
  assign mem_fault_o   = fault_q;

endmodule
